// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and the
// majority-of-3 vote used by the receiver (and the matching transmitter).
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, realigned to
// zero by a synchronous restart so a frame's ticks are phased to its start edge.
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (restart_i || cnt_q == LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    assign tick_o = !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit recovery,
// optional parity, 1/2 stop bits, valid/ready output with sticky overrun.
module uart_rx_cfg import uart_pkg::*; #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] SAMP_A  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMP_B  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] SAMP_C  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] BIT_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0)
    begin : g_bad_param
        $error("uart_rx_cfg: illegal parameter combination");
    end

    logic [1:0]           sync_q;
    logic                 rx_s, rx_prev_q;
    uart_state_e          state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q, data_q;
    logic                 par_q, perr_f_q, ferr_f_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q, busy_q;
    logic                 tick, restart, samp_c, bit_end, bit_val, par_exp, done, stop_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
        end
    end
    assign rx_s = sync_q[1];

    assign restart = (state_q == ST_IDLE) && rx_prev_q && !rx_s;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // The third sample completes the vote, so every bit decision is made there.
    assign samp_c    = tick && (tick_cnt_q == SAMP_C);
    assign bit_end   = tick && (tick_cnt_q == BIT_END);
    assign bit_val   = maj3(samp_q[1], samp_q[0], rx_s);
    assign par_exp   = (PARITY == PARITY_ODD) ? ~par_q : par_q;
    assign stop_ferr = ferr_f_q | ~bit_val;
    assign done      = (state_q == ST_STOP) && samp_c && (bit_cnt_q == LAST_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            perr_f_q   <= 1'b0;
            ferr_f_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (tick && (tick_cnt_q == SAMP_A || tick_cnt_q == SAMP_B))
                samp_q <= {samp_q[0], rx_s};
            if (tick)
                tick_cnt_q <= bit_end ? '0 : tick_cnt_q + 1'b1;

            case (state_q)
                ST_IDLE: if (restart) begin
                    state_q    <= ST_START;
                    busy_q     <= 1'b1;
                    tick_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    par_q      <= 1'b0;
                    perr_f_q   <= 1'b0;
                    ferr_f_q   <= 1'b0;
                end
                ST_START: begin
                    if (samp_c && bit_val) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (samp_c) begin
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        par_q   <= par_q ^ bit_val;
                    end
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            state_q   <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (samp_c)
                        perr_f_q <= bit_val ^ par_exp;
                    if (bit_end)
                        state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (samp_c) begin
                        ferr_f_q <= stop_ferr;
                        if (bit_cnt_q == LAST_STOP) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (bit_end) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A held, unaccepted word wins; the new frame is dropped and flagged.
            if (done) begin
                if (!valid_q || ready) begin
                    data_q  <= shift_q;
                    perr_q  <= perr_f_q;
                    ferr_q  <= stop_ferr;
                    valid_q <= 1'b1;
                    if (valid_q)
                        ovr_q <= 1'b0;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2) at DIV=8,
// frames checked against a scoreboard of expected words and flags.
module tb_uart_rx_cfg;
    localparam int CF   = 12000000;
    localparam int BR   = 93750;
    localparam int OS   = 16;
    localparam int DIV  = 8;
    localparam int BIT  = DIV * OS;
    localparam int NOFF = DIV * (OS / 2 + 1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, b0, b1, b2;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .data(d0), .valid(v0), .ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0));
    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data(d1), .valid(v1), .ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1));
    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .OVERSAMPLE(OS)) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx2), .data(d2), .valid(v2), .ready(rdy2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(b2));

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   nvalid[3] = '{0, 0, 0};
    int   vcyc[3]   = '{0, 0, 0};
    logic vprev[3]  = '{1'b0, 1'b0, 1'b0};
    logic       mv, mp, mf;
    logic [8:0] md;
    exp_t       me;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every rising valid pops the oldest expected word.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin mv = v0; md = {1'b0, d0};  mp = pe0; mf = fe0; end
                1:       begin mv = v1; md = {1'b0, d1};  mp = pe1; mf = fe1; end
                default: begin mv = v2; md = {2'b0, d2};  mp = pe2; mf = fe2; end
            endcase
            if (mv && !vprev[i]) begin
                nvalid[i]++;
                vcyc[i] = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid dut%0d data=%h perr=%b ferr=%b (nothing expected)",
                             i, md, mp, mf);
                end else begin
                    me = sb.pop_front();
                    if (me.dut !== i || md !== me.data || mp !== me.perr || mf !== me.ferr) begin
                        errors++;
                        $display("FAIL word dut%0d got data=%h perr=%b ferr=%b, want dut%0d data=%h perr=%b ferr=%b",
                                 i, md, mp, mf, me.dut, me.data, me.perr, me.ferr);
                    end
                end
            end
            vprev[i] = mv;
        end
    end

    task automatic set_rx(input int i, input logic v);
        case (i)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // pbit < 0: no parity bit; noise_bit: frame bit index that gets a
    // one-cycle inversion at its middle sample (-1 for none).
    task automatic send(input int i, input logic [8:0] d, input int nb, input int pbit,
                        input logic [1:0] stops, input int ns, input int noise_bit);
        logic bits[16];
        int   n;
        bits[0] = 1'b0;
        for (int k = 0; k < nb; k++) bits[1 + k] = d[k];
        n = 1 + nb;
        if (pbit >= 0) begin bits[n] = pbit[0]; n++; end
        for (int s = 0; s < ns; s++) begin bits[n] = stops[s]; n++; end
        @(negedge clk);
        for (int b = 0; b < n; b++) begin
            set_rx(i, bits[b]);
            for (int c = 0; c < BIT; c++) begin
                if (b == noise_bit && c == NOFF)     set_rx(i, ~bits[b]);
                if (b == noise_bit && c == NOFF + 1) set_rx(i, bits[b]);
                @(negedge clk);
            end
        end
        set_rx(i, 1'b1);
    endtask

    task automatic wait_valid(input int i, input int n0, output bit ok);
        int t = 0;
        while (nvalid[i] == n0 && t < 2 * BIT) begin @(negedge clk); t++; end
        ok = (nvalid[i] != n0);
    endtask

    task automatic test_reset;
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", d0); end
        checks++; if (v0 !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b want=0", v0); end
        checks++; if (pe0 !== 1'b0 || fe0 !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", pe0, fe0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", ov0); end
        checks++; if ({b0, b1, b2} !== 3'b000) begin errors++; $display("FAIL reset_busy got=%b want=000", {b0, b1, b2}); end
        checks++; if ({v1, v2} !== 2'b00) begin errors++; $display("FAIL reset_valid12 got=%b want=00", {v1, v2}); end
    endtask

    task automatic test_basic;
        int n0, t0, lat;
        bit ok;
        n0 = nvalid[0];
        t0 = 0;
        sb.push_back('{0, 9'h0A5, 1'b0, 1'b0});
        fork
            send(0, 9'h0A5, 8, -1, 2'b11, 1, -1);
            begin
                @(negedge clk);
                t0 = cyc;
                repeat (2) @(posedge clk);
                #1;
                checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL busy_early got=%b want=0", b0); end
                @(posedge clk);
                #1;
                checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL busy_rise got=%b want=1", b0); end
            end
        join
        wait_valid(0, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no valid want=valid"); end
        lat = vcyc[0] - t0;
        checks++;
        if (lat < (19 * BIT) / 2 + 3 - BIT || lat > (19 * BIT) / 2 + 3 + BIT) begin
            errors++;
            $display("FAIL basic_latency got=%0d want=%0d+-%0d", lat, (19 * BIT) / 2 + 3, BIT);
        end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got=%b want=0", v0); end
        checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL basic_data_hold got=%h want=a5", d0); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b want=0", b0); end
    endtask

    task automatic test_parity;
        int n0;
        bit ok;
        n0 = nvalid[1];
        sb.push_back('{1, 9'h037, 1'b0, 1'b0});
        send(1, 9'h037, 8, 1, 2'b11, 1, -1);
        wait_valid(1, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL parity_good_timeout got=no valid want=valid"); end
        n0 = nvalid[1];
        sb.push_back('{1, 9'h037, 1'b1, 1'b0});
        send(1, 9'h037, 8, 0, 2'b11, 1, -1);
        wait_valid(1, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL parity_bad_timeout got=no valid want=valid"); end
    endtask

    task automatic test_frame;
        int n0;
        bit ok;
        n0 = nvalid[2];
        sb.push_back('{2, 9'h041, 1'b0, 1'b1});
        send(2, 9'h041, 7, -1, 2'b01, 2, -1);
        wait_valid(2, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_err_timeout got=no valid want=valid"); end
        repeat (20) @(negedge clk);
        n0 = nvalid[2];
        sb.push_back('{2, 9'h07F, 1'b0, 1'b0});
        send(2, 9'h07F, 7, -1, 2'b11, 2, -1);
        wait_valid(2, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_ok_timeout got=no valid want=valid"); end
    endtask

    task automatic test_glitch;
        int n0;
        bit ok;
        n0 = nvalid[0];
        @(negedge clk);
        rx0 = 1'b0;
        repeat (30) @(negedge clk);
        rx0 = 1'b1;
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b want=1", b0); end
        repeat (2 * BIT) @(negedge clk);
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop got=%b want=0", b0); end
        checks++; if (nvalid[0] != n0) begin errors++; $display("FAIL glitch_no_valid got=%0d want=%0d", nvalid[0], n0); end
        sb.push_back('{0, 9'h03C, 1'b0, 1'b0});
        send(0, 9'h03C, 8, -1, 2'b11, 1, -1);
        wait_valid(0, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_next_timeout got=no valid want=valid"); end
    endtask

    task automatic test_overrun;
        int n0;
        rdy0 = 1'b0;
        n0 = nvalid[0];
        sb.push_back('{0, 9'h011, 1'b0, 1'b0});
        send(0, 9'h011, 8, -1, 2'b11, 1, -1);
        send(0, 9'h022, 8, -1, 2'b11, 1, -1);
        repeat (4) @(negedge clk);
        checks++; if (nvalid[0] != n0 + 1) begin errors++; $display("FAIL ovr_valid_count got=%0d want=%0d", nvalid[0] - n0, 1); end
        checks++; if (v0 !== 1'b1 || d0 !== 8'h11) begin errors++; $display("FAIL ovr_held got=%b/%h want=1/11", v0, d0); end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b want=1", ov0); end
        rdy0 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid got=%b want=0", v0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b want=0", ov0); end
        checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL ovr_data_after got=%h want=11", d0); end
        rdy0 = 1'b1;
    endtask

    task automatic test_noise;
        int n0;
        bit ok;
        n0 = nvalid[0];
        sb.push_back('{0, 9'h096, 1'b0, 1'b0});
        send(0, 9'h096, 8, -1, 2'b11, 1, 4);
        wait_valid(0, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL noise0_timeout got=no valid want=valid"); end
        n0 = nvalid[0];
        sb.push_back('{0, 9'h096, 1'b0, 1'b0});
        send(0, 9'h096, 8, -1, 2'b11, 1, 2);
        wait_valid(0, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL noise1_timeout got=no valid want=valid"); end
    endtask

    task automatic test_reset_mid;
        int n0;
        bit ok;
        fork
            send(0, 9'h05A, 8, -1, 2'b11, 1, -1);
            begin
                repeat (4 * BIT + 10) @(negedge clk);
                checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", b0); end
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({d0, v0, pe0, fe0, ov0, b0} !== 13'd0) begin
                    errors++;
                    $display("FAIL mid_reset got=%h/%b%b%b%b%b want=00/00000", d0, v0, pe0, fe0, ov0, b0);
                end
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n0 = nvalid[0];
        sb.push_back('{0, 9'h05A, 1'b0, 1'b0});
        send(0, 9'h05A, 8, -1, 2'b11, 1, -1);
        wait_valid(0, n0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL resend_timeout got=no valid want=valid"); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset;
        test_basic;
        repeat (10) @(negedge clk);
        test_parity;
        repeat (10) @(negedge clk);
        test_frame;
        repeat (10) @(negedge clk);
        test_glitch;
        repeat (10) @(negedge clk);
        test_overrun;
        repeat (10) @(negedge clk);
        test_noise;
        repeat (10) @(negedge clk);
        test_reset_mid;
        repeat (10) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty got=%0d want=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
